hex_glyph_writer: RTL and testbench
===================================

HEX_GLYPH_WRITER -- requirements
Module: hex_glyph_writer

Interface
REQ-001 Parameter NCH, default 20: number of 16-bit channels displayed.
REQ-002 Parameter DIGITS, default 4: hex digits shown per channel, range 1..4, taken from the low 4*DIGITS bits.
REQ-003 Parameter ADDR_W, default 11: video-memory address width.
REQ-004 Parameter BASE_ADDR, default 341: glyph-word address of channel 0, word 0.
REQ-005 Parameter ROW_STRIDE, default 27: address step between consecutive channels.
REQ-006 CLK  input  1: single clock; all state on its rising edge.
REQ-007 CLR  input  1: reset, asynchronous, active-high.
REQ-008 start  input  1: one-cycle request to begin a refresh pass; the driver pulses it when VPix==0.
REQ-009 values  input  16*NCH: channel c occupies bits [16c+15:16c].
REQ-010 ch_en  input  NCH: per-channel enable; a disabled channel generates no writes.
REQ-011 lz_sup  input  1: leading-zero suppression enable.
REQ-012 mem_ready  input  1: the memory port accepts the write in any cycle where mem_we && mem_ready.
REQ-013 mem_we  output  1: write strobe.
REQ-014 mem_addr  output  ADDR_W: write address.
REQ-015 mem_din  output  18: glyph word {g0[17:12], g1[11:6], g2[5:0]}.
REQ-016 busy  output  1: high from the cycle after an accepted start until done.
REQ-017 done  output  1: one-cycle pulse at the end of a pass.

Function
REQ-018 Glyph code for a hex nibble n SHALL be n+1, 6 bits; code 0 SHALL be blank.
REQ-019 Each channel SHALL emit WPC = ceil(DIGITS/3) words, with digits MSB-first and left-aligned; unused slots SHALL be 0. For DIGITS=4: word0={d3,d2,d1}, word1={d0,0,0}.
REQ-020 When lz_sup=1, leading zero digits SHALL be emitted as code 0; the least significant digit SHALL always be emitted as a digit.
REQ-021 The write address for channel c, word w SHALL be BASE_ADDR + c*ROW_STRIDE + w, truncated to ADDR_W bits (wrap-around allowed).
REQ-022 States: IDLE, SCAN, WRITE, DONE.
- IDLE: on start, snapshot values, ch_en and lz_sup, clear the channel index, go to SCAN.
- SCAN: skip disabled channels one per cycle. If an enabled channel is found, go to WRITE. If the index passes NCH-1, go to DONE.
- WRITE: drive the word; on acceptance advance w, and after word WPC-1 advance c and return to SCAN.
- DONE: pulse done for one cycle, then return to IDLE.
REQ-023 Writes SHALL use the snapshot only; input changes during a pass SHALL have no effect until the next pass.
REQ-024 mem_we, mem_addr and mem_din SHALL be registered and SHALL stay stable while mem_we=1 and mem_ready=0.
REQ-025 With mem_ready held high, accepted writes SHALL occur on consecutive cycles within a channel; SCAN SHALL cost exactly one cycle per channel index visited.
REQ-026 start asserted while busy=1 or in DONE SHALL be ignored.
REQ-027 If ch_en is all-zero, a pass SHALL issue no writes and SHALL pulse done within NCH+2 cycles of start.
REQ-028 mem_we SHALL be 0 in IDLE, SCAN and DONE.

Reset
REQ-029 While CLR=1: state=IDLE, mem_we=0, mem_addr=0, mem_din=0, busy=0, done=0, and all indices and snapshots cleared.
REQ-030 CLR asserted mid-pass SHALL abort the pass immediately, with no further writes and no done pulse.
REQ-031 After CLR deasserts, the block SHALL wait for a new start.

Verification
REQ-032 NCH=2, ch_en=2'b01, values[15:0]=16'h1A3F, lz_sup=0, mem_ready=1, start pulse -> writes (341, {2,11,4}) then (342, {16,0,0}); done one cycle after the last write; exactly 2 writes.
REQ-033 Same setup, values[15:0]=16'h0005, lz_sup=1 -> (341, {0,0,0}), (342, {6,0,0}).
REQ-034 ch_en=2'b10 -> writes only at 368 and 369; addresses 341 and 342 are never written.
REQ-035 Hold mem_ready=0 for 5 cycles during the first write -> mem_we, mem_addr and mem_din are unchanged for those cycles; the write completes one cycle after mem_ready rises.
REQ-036 Change values and pulse start again mid-pass -> written data equals the first snapshot and no second pass begins; CLR pulse mid-pass -> outputs zero in the same cycle and done never fires.
REQ-037 ch_en=0 -> zero writes; done is pulsed within NCH+2 cycles.

Source files
------------

// File: rtl/hex_glyph_writer_if.sv
// Video-memory write port carrying one 18-bit glyph word per accepted beat.
interface hex_glyph_writer_if #(
    parameter int ADDR_W = 11
);
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [17:0]       mem_din;
    logic              mem_ready;

    modport master (output mem_we, output mem_addr, output mem_din, input mem_ready);
    modport slave  (input mem_we, input mem_addr, input mem_din, output mem_ready);
endinterface

// File: rtl/hex_glyph_writer.sv
// Renders NCH 16-bit channel values as hex glyph words into video memory,
// one refresh pass per start pulse, working from a snapshot taken at start.
module hex_glyph_writer #(
    parameter int NCH        = 20,
    parameter int DIGITS     = 4,
    parameter int ADDR_W     = 11,
    parameter int BASE_ADDR  = 341,
    parameter int ROW_STRIDE = 27
) (
    input  logic                  CLK,
    input  logic                  CLR,
    input  logic                  start,
    input  logic [16*NCH-1:0]     values,
    input  logic [NCH-1:0]        ch_en,
    input  logic                  lz_sup,
    output logic                  busy,
    output logic                  done,
    hex_glyph_writer_if.master    mem
);
    localparam int WPC = (DIGITS + 2) / 3;
    localparam int WW  = (WPC > 1) ? $clog2(WPC) : 1;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_WRITE, S_DONE} state_t;

    state_t            r_state;
    logic [16*NCH-1:0] r_vals;
    logic [NCH-1:0]    r_en;
    logic              r_lz;
    logic [CW-1:0]     r_c;
    logic [WW-1:0]     r_w;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [17:0]       r_din;
    logic              r_busy;
    logic              r_done;

    logic [15:0]       w_val;
    logic [NCH-1:0]    w_higher;
    logic              w_last_word;
    logic [WW-1:0]     w_next_w;

    // Glyph codes are nibble+1; blank (0) marks leading zeros and unused slots.
    function automatic logic [17:0] glyph_word(input logic [15:0] v, input logic lz, input int w);
        logic [17:0] r;
        logic        lead;
        logic [3:0]  n;
        int          k;
        r    = 18'd0;
        lead = lz;
        for (int p = 0; p < DIGITS; p++) begin
            k = DIGITS - 1 - p;
            n = v[4*k +: 4];
            if (n != 4'd0 || k == 0) lead = 1'b0;
            if (p / 3 == w) r[17 - 6*(p % 3) -: 6] = lead ? 6'd0 : ({2'b00, n} + 6'd1);
        end
        return r;
    endfunction

    function automatic logic [ADDR_W-1:0] addr_of(input int c, input int w);
        return ADDR_W'(BASE_ADDR + c * ROW_STRIDE + w);
    endfunction

    assign w_val       = r_vals[16*r_c +: 16];
    // Any enabled channel above the current one; lets the last write go straight to DONE.
    assign w_higher    = (r_en >> r_c) >> 1;
    assign w_last_word = (r_w == WW'(WPC - 1));
    assign w_next_w    = r_w + {{(WW-1){1'b0}}, 1'b1};

    assign mem.mem_we   = r_we;
    assign mem.mem_addr = r_addr;
    assign mem.mem_din  = r_din;
    assign busy         = r_busy;
    assign done         = r_done;

    // Pass controller: snapshot, channel scan, stalled word writes, done pulse.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_state <= S_IDLE;
            r_vals  <= '0;
            r_en    <= '0;
            r_lz    <= 1'b0;
            r_c     <= '0;
            r_w     <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_din   <= 18'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_vals  <= values;
                        r_en    <= ch_en;
                        r_lz    <= lz_sup;
                        r_c     <= '0;
                        r_w     <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (r_en[r_c]) begin
                        r_we    <= 1'b1;
                        r_w     <= '0;
                        r_addr  <= addr_of(int'(r_c), 32'sd0);
                        r_din   <= glyph_word(w_val, r_lz, 32'sd0);
                        r_state <= S_WRITE;
                    end else if (r_c == CW'(NCH - 1)) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_c <= r_c + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                S_WRITE: begin
                    if (mem.mem_ready) begin
                        if (w_last_word) begin
                            r_we <= 1'b0;
                            r_w  <= '0;
                            if (w_higher == '0) begin
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end else begin
                                r_c     <= r_c + {{(CW-1){1'b0}}, 1'b1};
                                r_state <= S_SCAN;
                            end
                        end else begin
                            r_w    <= w_next_w;
                            r_addr <= addr_of(int'(r_c), int'(w_next_w));
                            r_din  <= glyph_word(w_val, r_lz, int'(w_next_w));
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_we    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hex_glyph_writer.sv
// Directed bench for hex_glyph_writer with NCH=2, DIGITS=4 and default addressing.
module tb_hex_glyph_writer;
    localparam int NCH = 2;

    logic        CLK = 1'b0;
    logic        CLR = 1'b1;
    logic        start = 1'b0;
    logic [31:0] values = 32'h0;
    logic [1:0]  ch_en = 2'b00;
    logic        lz_sup = 1'b0;
    logic        busy, done;

    hex_glyph_writer_if #(.ADDR_W(11)) mem_bus ();

    hex_glyph_writer #(.NCH(NCH), .DIGITS(4), .ADDR_W(11), .BASE_ADDR(341), .ROW_STRIDE(27)) dut (
        .CLK(CLK), .CLR(CLR), .start(start), .values(values), .ch_en(ch_en),
        .lz_sup(lz_sup), .busy(busy), .done(done), .mem(mem_bus)
    );

    always #5 CLK = ~CLK;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [10:0] wa_q[$];
    logic [17:0] wd_q[$];
    int          wc_q[$];
    int          done_cnt = 0;
    int          done_cyc = 0;

    always @(posedge CLK) cyc++;

    // Write/done logger sampled mid-cycle, where inputs and outputs are settled.
    always @(negedge CLK) begin
        if (mem_bus.mem_we && mem_bus.mem_ready) begin
            wa_q.push_back(mem_bus.mem_addr);
            wd_q.push_back(mem_bus.mem_din);
            wc_q.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic clear_log;
        wa_q.delete(); wd_q.delete(); wc_q.delete();
        done_cnt = 0;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output bit ok);
        int k = 0;
        while (done_cnt == 0 && k < limit) begin tick(1); k++; end
        ok = (done_cnt != 0);
    endtask

    task automatic wait_we(input int limit, output bit ok);
        int k = 0;
        while (mem_bus.mem_we !== 1'b1 && k < limit) begin tick(1); k++; end
        ok = (mem_bus.mem_we === 1'b1);
    endtask

    task automatic test_reset;
        tick(2);
        n_checks++;
        if ({mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_din, busy, done} !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got we=%b addr=%0d din=%h busy=%b done=%b, want all 0",
                     mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_din, busy, done);
        end
        CLR = 1'b0;
        tick(2);
    endtask

    task automatic test_basic;
        bit ok;
        values = 32'h0000_1A3F; ch_en = 2'b01; lz_sup = 1'b0; mem_bus.mem_ready = 1'b1;
        clear_log();
        pulse_start();
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", busy); end
        wait_done(50, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL basic_done_timeout: done not seen, want pulse"); end
        n_checks++;
        if (wa_q.size() != 2) begin n_fail++; $display("FAIL basic_count: got %0d writes want 2", wa_q.size()); end
        else begin
            n_checks++;
            if (wa_q[0] !== 11'd341 || wd_q[0] !== {6'd2, 6'd11, 6'd4}) begin
                n_fail++; $display("FAIL basic_w0: got (%0d,%h) want (341,%h)", wa_q[0], wd_q[0], {6'd2, 6'd11, 6'd4});
            end
            n_checks++;
            if (wa_q[1] !== 11'd342 || wd_q[1] !== {6'd16, 6'd0, 6'd0}) begin
                n_fail++; $display("FAIL basic_w1: got (%0d,%h) want (342,%h)", wa_q[1], wd_q[1], {6'd16, 6'd0, 6'd0});
            end
            n_checks++;
            if (done_cyc != wc_q[1] + 1) begin
                n_fail++; $display("FAIL basic_done_timing: done at %0d, want %0d", done_cyc, wc_q[1] + 1);
            end
        end
        tick(4);
        n_checks++;
        if (done_cnt != 1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL basic_single_done: got done_cnt=%0d busy=%b want 1,0", done_cnt, busy);
        end
    endtask

    task automatic test_lz;
        bit ok;
        values = 32'h0000_0005; ch_en = 2'b01; lz_sup = 1'b1;
        clear_log();
        pulse_start();
        wait_done(50, ok);
        tick(2);
        n_checks++;
        if (wa_q.size() != 2) begin n_fail++; $display("FAIL lz_count: got %0d writes want 2", wa_q.size()); end
        else begin
            n_checks++;
            if (wa_q[0] !== 11'd341 || wd_q[0] !== 18'd0 || wa_q[1] !== 11'd342 || wd_q[1] !== {6'd6, 6'd0, 6'd0}) begin
                n_fail++; $display("FAIL lz_data: got (%0d,%h)(%0d,%h) want (341,0)(342,%h)",
                                   wa_q[0], wd_q[0], wa_q[1], wd_q[1], {6'd6, 6'd0, 6'd0});
            end
        end
    endtask

    task automatic test_high_channel;
        bit ok;
        values = 32'h00C0_1234; ch_en = 2'b10; lz_sup = 1'b1;
        clear_log();
        pulse_start();
        wait_done(50, ok);
        tick(2);
        n_checks++;
        if (wa_q.size() != 2) begin n_fail++; $display("FAIL high_count: got %0d writes want 2", wa_q.size()); end
        else begin
            n_checks++;
            if (wa_q[0] !== 11'd368 || wd_q[0] !== {6'd0, 6'd0, 6'd13} || wa_q[1] !== 11'd369 || wd_q[1] !== {6'd1, 6'd0, 6'd0}) begin
                n_fail++; $display("FAIL high_data: got (%0d,%h)(%0d,%h) want (368,%h)(369,%h)",
                                   wa_q[0], wd_q[0], wa_q[1], wd_q[1], {6'd0, 6'd0, 6'd13}, {6'd1, 6'd0, 6'd0});
            end
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        logic [10:0] ea[4];
        logic [17:0] ed[4];
        ea = '{11'd341, 11'd342, 11'd368, 11'd369};
        ed = '{{6'd1, 6'd1, 6'd1}, {6'd1, 6'd0, 6'd0}, {6'd16, 6'd16, 6'd16}, {6'd16, 6'd0, 6'd0}};
        values = 32'hFFFF_0000; ch_en = 2'b11; lz_sup = 1'b0;
        clear_log();
        pulse_start();
        wait_done(50, ok);
        tick(2);
        n_checks++;
        if (wa_q.size() != 4) begin n_fail++; $display("FAIL b2b_count: got %0d writes want 4", wa_q.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (wa_q[i] !== ea[i] || wd_q[i] !== ed[i]) begin
                    n_fail++; $display("FAIL b2b_w%0d: got (%0d,%h) want (%0d,%h)", i, wa_q[i], wd_q[i], ea[i], ed[i]);
                end
            end
            n_checks++;
            if (wc_q[1] != wc_q[0] + 1 || wc_q[3] != wc_q[2] + 1 || wc_q[2] != wc_q[1] + 2) begin
                n_fail++; $display("FAIL b2b_timing: write cycles %0d %0d %0d %0d, want c,c+1,c+3,c+4",
                                   wc_q[0], wc_q[1], wc_q[2], wc_q[3]);
            end
        end
    endtask

    task automatic test_stall;
        bit ok;
        values = 32'h0000_1A3F; ch_en = 2'b01; lz_sup = 1'b0; mem_bus.mem_ready = 1'b0;
        clear_log();
        pulse_start();
        wait_we(20, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL stall_we_timeout: mem_we never rose"); end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (mem_bus.mem_we !== 1'b1 || mem_bus.mem_addr !== 11'd341 || mem_bus.mem_din !== {6'd2, 6'd11, 6'd4}) begin
                n_fail++; $display("FAIL stall_hold%0d: got we=%b (%0d,%h) want 1 (341,%h)", i,
                                   mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_din, {6'd2, 6'd11, 6'd4});
            end
            tick(1);
        end
        mem_bus.mem_ready = 1'b1;
        tick(1);
        n_checks++;
        if (mem_bus.mem_we !== 1'b1 || mem_bus.mem_addr !== 11'd342) begin
            n_fail++; $display("FAIL stall_release: got we=%b addr=%0d want 1,342", mem_bus.mem_we, mem_bus.mem_addr);
        end
        wait_done(20, ok);
        tick(2);
        n_checks++;
        if (wa_q.size() != 2) begin n_fail++; $display("FAIL stall_count: got %0d writes want 2", wa_q.size()); end
    endtask

    task automatic test_snapshot;
        bit ok;
        values = 32'h0000_1A3F; ch_en = 2'b01; lz_sup = 1'b0; mem_bus.mem_ready = 1'b0;
        clear_log();
        pulse_start();
        tick(2);
        values = 32'hFFFF_FFFF; ch_en = 2'b11; lz_sup = 1'b1;
        pulse_start();
        mem_bus.mem_ready = 1'b1;
        wait_done(50, ok);
        tick(20);
        n_checks++;
        if (wa_q.size() != 2 || done_cnt != 1) begin
            n_fail++; $display("FAIL snap_count: got %0d writes %0d dones want 2,1", wa_q.size(), done_cnt);
        end else begin
            n_checks++;
            if (wa_q[0] !== 11'd341 || wd_q[0] !== {6'd2, 6'd11, 6'd4} || wa_q[1] !== 11'd342 || wd_q[1] !== {6'd16, 6'd0, 6'd0}) begin
                n_fail++; $display("FAIL snap_data: got (%0d,%h)(%0d,%h) want first snapshot", wa_q[0], wd_q[0], wa_q[1], wd_q[1]);
            end
        end
    endtask

    task automatic test_clr_abort;
        bit ok;
        values = 32'h0000_1A3F; ch_en = 2'b11; lz_sup = 1'b0; mem_bus.mem_ready = 1'b0;
        clear_log();
        pulse_start();
        wait_we(20, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL clr_we_timeout: mem_we never rose"); end
        CLR = 1'b1;
        #1;
        n_checks++;
        if ({mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_din, busy, done} !== 32'h0) begin
            n_fail++; $display("FAIL clr_async: got we=%b addr=%0d din=%h busy=%b want all 0",
                               mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_din, busy);
        end
        mem_bus.mem_ready = 1'b1;
        tick(2);
        CLR = 1'b0;
        clear_log();
        tick(30);
        n_checks++;
        if (wa_q.size() != 0 || done_cnt != 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL clr_quiet: got %0d writes %0d dones busy=%b want 0,0,0", wa_q.size(), done_cnt, busy);
        end
    endtask

    task automatic test_all_disabled;
        bit ok;
        int cs;
        values = 32'h1234_5678; ch_en = 2'b00; lz_sup = 1'b0;
        clear_log();
        pulse_start();
        cs = cyc;
        wait_done(NCH + 4, ok);
        tick(2);
        n_checks++;
        if (!ok || done_cyc - cs > NCH + 2 || wa_q.size() != 0) begin
            n_fail++; $display("FAIL none_enabled: done_seen=%0d after %0d cycles with %0d writes, want done within %0d and 0 writes",
                               ok, done_cyc - cs, wa_q.size(), NCH + 2);
        end
    endtask

    initial begin
        mem_bus.mem_ready = 1'b1;
        test_reset();
        test_basic();
        test_lz();
        test_high_channel();
        test_back_to_back();
        test_stall();
        test_snapshot();
        test_clr_abort();
        test_all_disabled();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
